// File: rtl/wbi_slave_port.sv
// Daisy-chain Wishbone target node: local slave cycles for address hits,
// pass-through for misses, round-robin merge of local and downstream responses.
module wbi_slave_port #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              BW       = 4,
   parameter int              BL       = 10,
   parameter logic [AW-1:0]   SLV_BASE = 32'h0000_0000,
   parameter logic [AW-1:0]   SLV_MASK = 32'hF000_0000
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          wbd_cmd_wval_i,
   output logic          wbd_cmd_wrdy_o,
   input  logic [AW-1:0] wbd_cmd_adr_i,
   input  logic          wbd_cmd_we_i,
   input  logic [DW-1:0] wbd_cmd_dat_i,
   input  logic [BW-1:0] wbd_cmd_sel_i,
   input  logic [3:0]    wbd_cmd_tid_i,
   input  logic [BL-1:0] wbd_cmd_bl_i,
   output logic          wbd_res_rval_o,
   input  logic          wbd_res_rrdy_i,
   output logic [DW-1:0] wbd_res_dat_o,
   output logic          wbd_res_ack_o,
   output logic          wbd_res_lack_o,
   output logic          wbd_res_err_o,
   output logic [3:0]    wbd_res_tid_o,
   output logic          wbn_cmd_wval_o,
   input  logic          wbn_cmd_wrdy_i,
   output logic [AW-1:0] wbn_cmd_adr_o,
   output logic          wbn_cmd_we_o,
   output logic [DW-1:0] wbn_cmd_dat_o,
   output logic [BW-1:0] wbn_cmd_sel_o,
   output logic [3:0]    wbn_cmd_tid_o,
   output logic [BL-1:0] wbn_cmd_bl_o,
   input  logic          wbn_res_rval_i,
   output logic          wbn_res_rrdy_o,
   input  logic [DW-1:0] wbn_res_dat_i,
   input  logic          wbn_res_ack_i,
   input  logic          wbn_res_lack_i,
   input  logic          wbn_res_err_i,
   input  logic [3:0]    wbn_res_tid_i,
   output logic          wbs_cyc_o,
   output logic          wbs_stb_o,
   output logic          wbs_we_o,
   output logic [AW-1:0] wbs_adr_o,
   output logic [DW-1:0] wbs_dat_o,
   output logic [BW-1:0] wbs_sel_o,
   output logic [BL-1:0] wbs_bl_o,
   output logic          wbs_bry_o,
   input  logic [DW-1:0] wbs_dat_i,
   input  logic          wbs_ack_i,
   input  logic          wbs_lack_i,
   input  logic          wbs_err_i
);

   typedef enum logic {IDLE, XFER} state_t;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic          err;
      logic          lack;
      logic [3:0]    tid;
   } rsp_t;

   state_t        state;
   logic [3:0]    tid_q;
   logic [BL-1:0] beats_q;
   logic [BL-1:0] cnt_q;

   logic hit;
   logic idle;
   logic accept;
   logic push;
   logic pop;
   logic final_beat;

   rsp_t       mem [2];
   rsp_t       head;
   logic       wp;
   logic       rp;
   logic [1:0] fcnt;
   logic       full;
   logic       loc_v;

   logic ptr_q;
   logic lock_q;
   logic lock_dn_q;
   logic grant_dn;
   logic xfer_up;

   assign hit    = (wbd_cmd_adr_i & SLV_MASK) == SLV_BASE;
   assign idle   = (state == IDLE);
   assign accept = ~reset & wbd_cmd_wval_i & hit & idle;

   assign wbd_cmd_wrdy_o = ~reset & (hit ? idle : wbn_cmd_wrdy_i);
   assign wbn_cmd_wval_o = ~reset & wbd_cmd_wval_i & ~hit;
   assign wbn_cmd_adr_o  = wbd_cmd_adr_i;
   assign wbn_cmd_we_o   = wbd_cmd_we_i;
   assign wbn_cmd_dat_o  = wbd_cmd_dat_i;
   assign wbn_cmd_sel_o  = wbd_cmd_sel_i;
   assign wbn_cmd_tid_o  = wbd_cmd_tid_i;
   assign wbn_cmd_bl_o   = wbd_cmd_bl_i;

   assign push       = (state == XFER) & (wbs_ack_i | wbs_err_i);
   assign final_beat = (cnt_q == beats_q - BL'(1)) | wbs_lack_i;

   always_ff @(posedge mclk) begin
      if (reset) begin
         state     <= IDLE;
         wbs_cyc_o <= 1'b0;
         wbs_stb_o <= 1'b0;
         wbs_we_o  <= 1'b0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_sel_o <= '0;
         wbs_bl_o  <= '0;
         tid_q     <= '0;
         beats_q   <= '0;
         cnt_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state     <= XFER;
                  wbs_cyc_o <= 1'b1;
                  wbs_stb_o <= 1'b1;
                  wbs_we_o  <= wbd_cmd_we_i;
                  wbs_adr_o <= wbd_cmd_adr_i;
                  wbs_dat_o <= wbd_cmd_dat_i;
                  wbs_sel_o <= wbd_cmd_sel_i;
                  wbs_bl_o  <= wbd_cmd_bl_i;
                  tid_q     <= wbd_cmd_tid_i;
                  cnt_q     <= '0;
                  // writes are always single beat; bl==0 reads mean one beat
                  beats_q   <= (wbd_cmd_we_i || wbd_cmd_bl_i == '0)
                               ? BL'(1) : wbd_cmd_bl_i;
               end
            end
            XFER: begin
               if (push) begin
                  cnt_q <= cnt_q + BL'(1);
                  if (final_beat | wbs_err_i) begin
                     state     <= IDLE;
                     wbs_cyc_o <= 1'b0;
                     wbs_stb_o <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign full      = (fcnt == 2'd2);
   assign loc_v     = (fcnt != 2'd0);
   assign head      = mem[rp];
   assign wbs_bry_o = ~reset & ~full;

   always_ff @(posedge mclk) begin
      if (reset) begin
         wp     <= 1'b0;
         rp     <= 1'b0;
         fcnt   <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wp].dat  <= wbs_we_o ? '0 : wbs_dat_i;
            mem[wp].err  <= wbs_err_i;
            mem[wp].lack <= final_beat | wbs_err_i;
            mem[wp].tid  <= tid_q;
            wp           <= ~wp;
         end
         if (pop)
            rp <= ~rp;
         fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_comb begin
      grant_dn = 1'b0;
      if (lock_q)
         grant_dn = lock_dn_q;
      else if (ptr_q)
         grant_dn = wbn_res_rval_i | ~loc_v;
      else
         grant_dn = wbn_res_rval_i & ~loc_v;
   end

   assign wbd_res_rval_o = ~reset & (grant_dn ? wbn_res_rval_i : loc_v);
   assign wbd_res_dat_o  = grant_dn ? wbn_res_dat_i  : head.dat;
   assign wbd_res_ack_o  = grant_dn ? wbn_res_ack_i  : (loc_v & ~head.err);
   assign wbd_res_lack_o = grant_dn ? wbn_res_lack_i : head.lack;
   assign wbd_res_err_o  = grant_dn ? wbn_res_err_i  : head.err;
   assign wbd_res_tid_o  = grant_dn ? wbn_res_tid_i  : head.tid;
   assign wbn_res_rrdy_o = ~reset & grant_dn & wbd_res_rrdy_i;

   assign xfer_up = wbd_res_rval_o & wbd_res_rrdy_i;
   assign pop     = xfer_up & ~grant_dn;

   always_ff @(posedge mclk) begin
      if (reset) begin
         ptr_q     <= 1'b0;
         lock_q    <= 1'b0;
         lock_dn_q <= 1'b0;
      end else begin
         // a stalled beat keeps its grant so its fields cannot change
         lock_q    <= wbd_res_rval_o & ~wbd_res_rrdy_i;
         lock_dn_q <= grant_dn;
         if (xfer_up)
            ptr_q <= ~grant_dn;
      end
   end

   always_ff @(posedge mclk) begin
      if (!reset && push)
         assert (!full || pop);
   end

endmodule
